// File: rtl/fft_r4_bfly_issue.sv
// Radix-4 DIF butterfly that issues branches 1..3 to the twiddle multiplier
// and re-joins branch 0, held in an alignment FIFO, with the returned products.
module fft_r4_bfly_issue #(
  parameter int SIZE_DATA_FI = 4,
  parameter int DATA_W       = 16,
  parameter     TYPE         = "forvard",
  parameter int B0_DEPTH     = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sof,
  input  logic [DATA_W-1:0]   i_a_i,
  input  logic [DATA_W-1:0]   i_a_q,
  input  logic [DATA_W-1:0]   i_b_i,
  input  logic [DATA_W-1:0]   i_b_q,
  input  logic [DATA_W-1:0]   i_c_i,
  input  logic [DATA_W-1:0]   i_c_q,
  input  logic [DATA_W-1:0]   i_d_i,
  input  logic [DATA_W-1:0]   i_d_q,
  output logic                o_mul_en,
  output logic [DATA_W+1:0]   o_mul_data1_i,
  output logic [DATA_W+1:0]   o_mul_data1_q,
  output logic [DATA_W+1:0]   o_mul_data2_i,
  output logic [DATA_W+1:0]   o_mul_data2_q,
  output logic [DATA_W+1:0]   o_mul_data3_i,
  output logic [DATA_W+1:0]   o_mul_data3_q,
  output logic [15:0]         o_mul_fi_deg,
  input  logic                i_mul_valid,
  input  logic [DATA_W+3:0]   i_mul_data1_i,
  input  logic [DATA_W+3:0]   i_mul_data1_q,
  input  logic [DATA_W+3:0]   i_mul_data2_i,
  input  logic [DATA_W+3:0]   i_mul_data2_q,
  input  logic [DATA_W+3:0]   i_mul_data3_i,
  input  logic [DATA_W+3:0]   i_mul_data3_q,
  output logic                o_valid,
  output logic [DATA_W+3:0]   o_y0_i,
  output logic [DATA_W+3:0]   o_y0_q,
  output logic [DATA_W+3:0]   o_y1_i,
  output logic [DATA_W+3:0]   o_y1_q,
  output logic [DATA_W+3:0]   o_y2_i,
  output logic [DATA_W+3:0]   o_y2_q,
  output logic [DATA_W+3:0]   o_y3_i,
  output logic [DATA_W+3:0]   o_y3_q,
  output logic                o_err
);
  localparam int W2  = DATA_W + 2;
  localparam int W4  = DATA_W + 4;
  localparam int KW  = SIZE_DATA_FI - 2;
  localparam int AW  = $clog2(B0_DEPTH);
  localparam int CW  = AW + 1;
  localparam bit INV = (TYPE == "invers");
  localparam logic [KW-1:0] K_ONE = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] A_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic signed [W2-1:0] sx2(input logic [DATA_W-1:0] v);
    return {{2{v[DATA_W-1]}}, v};
  endfunction

  function automatic logic [W4-1:0] sx4(input logic [W2-1:0] v);
    return {{2{v[W2-1]}}, v};
  endfunction

  logic signed [W2-1:0] t0_i_s, t0_q_s, t1_i_s, t1_q_s, t2_i_s, t2_q_s, t3_i_s, t3_q_s;
  logic signed [W2-1:0] y0_i_s, y0_q_s, y1_i_s, y1_q_s, y2_i_s, y2_q_s, y3_i_s, y3_q_s;
  logic                 accept_s, push_s, pop_s, uflow_s;
  logic [KW-1:0]        k_q, k_d, k_use_s;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW:0]          occ_s;
  logic [AW-1:0]        wr_q, rd_q;
  logic [2*W4-1:0]      fifo_q [B0_DEPTH];

  logic                 mul_en_q;
  logic [W2-1:0]        d1_i_q, d1_q_q, d2_i_q, d2_q_q, d3_i_q, d3_q_q, y0_i_q, y0_q_q;
  logic [15:0]          fi_q;
  logic                 valid_q, err_q;
  logic [W4-1:0]        oy0_i_q, oy0_q_q, oy1_i_q, oy1_q_q, oy2_i_q, oy2_q_q, oy3_i_q, oy3_q_q;

  // Butterfly; -j*t3 = (t3_q, -t3_i), branch 1 takes -j*t3 forward and +j*t3 inverse
  always_comb begin
    t0_i_s = sx2(i_a_i) + sx2(i_c_i);
    t0_q_s = sx2(i_a_q) + sx2(i_c_q);
    t1_i_s = sx2(i_a_i) - sx2(i_c_i);
    t1_q_s = sx2(i_a_q) - sx2(i_c_q);
    t2_i_s = sx2(i_b_i) + sx2(i_d_i);
    t2_q_s = sx2(i_b_q) + sx2(i_d_q);
    t3_i_s = sx2(i_b_i) - sx2(i_d_i);
    t3_q_s = sx2(i_b_q) - sx2(i_d_q);
    y0_i_s = t0_i_s + t2_i_s;
    y0_q_s = t0_q_s + t2_q_s;
    y2_i_s = t0_i_s - t2_i_s;
    y2_q_s = t0_q_s - t2_q_s;
    if (INV) begin
      y1_i_s = t1_i_s - t3_q_s;
      y1_q_s = t1_q_s + t3_i_s;
      y3_i_s = t1_i_s + t3_q_s;
      y3_q_s = t1_q_s - t3_i_s;
    end else begin
      y1_i_s = t1_i_s + t3_q_s;
      y1_q_s = t1_q_s - t3_i_s;
      y3_i_s = t1_i_s - t3_q_s;
      y3_q_s = t1_q_s + t3_i_s;
    end
  end

  // The group being issued counts toward occupancy so a push can never overflow
  assign occ_s    = {1'b0, cnt_q} + {{CW{1'b0}}, mul_en_q};
  assign o_ready  = (occ_s < (CW+1)'(B0_DEPTH));
  assign accept_s = i_valid & o_ready;
  assign k_use_s  = i_sof ? {KW{1'b0}} : k_q;
  assign push_s   = mul_en_q;
  assign pop_s    = i_mul_valid & (cnt_q != {CW{1'b0}});
  assign uflow_s  = i_mul_valid & (cnt_q == {CW{1'b0}});

  // Next-state for twiddle counter and FIFO occupancy
  always_comb begin
    k_d   = k_q;
    cnt_d = cnt_q;
    if (accept_s) k_d = k_use_s + K_ONE;
    else          k_d = k_q;
    if (push_s && !pop_s)      cnt_d = cnt_q + C_ONE;
    else if (!push_s && pop_s) cnt_d = cnt_q - C_ONE;
    else                       cnt_d = cnt_q;
  end

  // Issue register: multiplier operands, twiddle index and branch-0 staging
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mul_en_q <= 1'b0;
      k_q      <= {KW{1'b0}};
      fi_q     <= 16'h0000;
      d1_i_q   <= {W2{1'b0}};
      d1_q_q   <= {W2{1'b0}};
      d2_i_q   <= {W2{1'b0}};
      d2_q_q   <= {W2{1'b0}};
      d3_i_q   <= {W2{1'b0}};
      d3_q_q   <= {W2{1'b0}};
      y0_i_q   <= {W2{1'b0}};
      y0_q_q   <= {W2{1'b0}};
    end else begin
      mul_en_q <= accept_s;
      k_q      <= k_d;
      if (accept_s) begin
        fi_q   <= {{(16-KW){1'b0}}, k_use_s};
        d1_i_q <= y1_i_s;
        d1_q_q <= y1_q_s;
        d2_i_q <= y2_i_s;
        d2_q_q <= y2_q_s;
        d3_i_q <= y3_i_s;
        d3_q_q <= y3_q_s;
        y0_i_q <= y0_i_s;
        y0_q_q <= y0_q_s;
      end
    end
  end

  // Branch-0 storage; contents need no reset since pointers define validity
  always_ff @(posedge i_clk) begin
    if (push_s) fifo_q[wr_q] <= {sx4(y0_i_q), sx4(y0_q_q)};
  end

  // FIFO pointers, output beat and sticky underflow flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q    <= {AW{1'b0}};
      rd_q    <= {AW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      oy0_i_q <= {W4{1'b0}};
      oy0_q_q <= {W4{1'b0}};
      oy1_i_q <= {W4{1'b0}};
      oy1_q_q <= {W4{1'b0}};
      oy2_i_q <= {W4{1'b0}};
      oy2_q_q <= {W4{1'b0}};
      oy3_i_q <= {W4{1'b0}};
      oy3_q_q <= {W4{1'b0}};
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= pop_s;
      err_q   <= err_q | uflow_s;
      if (push_s) wr_q <= wr_q + A_ONE;
      if (pop_s) begin
        rd_q    <= rd_q + A_ONE;
        oy0_i_q <= fifo_q[rd_q][2*W4-1:W4];
        oy0_q_q <= fifo_q[rd_q][W4-1:0];
        oy1_i_q <= i_mul_data1_i;
        oy1_q_q <= i_mul_data1_q;
        oy2_i_q <= i_mul_data2_i;
        oy2_q_q <= i_mul_data2_q;
        oy3_i_q <= i_mul_data3_i;
        oy3_q_q <= i_mul_data3_q;
      end
    end
  end

  assign o_mul_en      = mul_en_q;
  assign o_mul_fi_deg  = fi_q;
  assign o_mul_data1_i = d1_i_q;
  assign o_mul_data1_q = d1_q_q;
  assign o_mul_data2_i = d2_i_q;
  assign o_mul_data2_q = d2_q_q;
  assign o_mul_data3_i = d3_i_q;
  assign o_mul_data3_q = d3_q_q;
  assign o_valid       = valid_q;
  assign o_err         = err_q;
  assign o_y0_i        = oy0_i_q;
  assign o_y0_q        = oy0_q_q;
  assign o_y1_i        = oy1_i_q;
  assign o_y1_q        = oy1_q_q;
  assign o_y2_i        = oy2_i_q;
  assign o_y2_q        = oy2_q_q;
  assign o_y3_i        = oy3_i_q;
  assign o_y3_q        = oy3_q_q;
endmodule

// File: tb/tb_fft_r4_bfly_issue.sv
// Bench for fft_r4_bfly_issue: directed table, random groups through a
// latency-5 multiplier model, backpressure, underflow and mid-burst reset.
module tb_fft_r4_bfly_issue;
  localparam int LAT  = 5;
  localparam int NFFT = 16;

  typedef struct { int k, y0i, y0q, y1i, y1q, y2i, y2q, y3i, y3q; } exp_t;
  typedef struct { bit rst; bit sof; int ai, aq, bi, bq, ci, cq, di, dq; exp_t e; } vec_t;
  typedef struct { int due; logic [19:0] d1i, d1q, d2i, d2q, d3i, d3q; } mul_t;

  logic clk, rst_n, valid, sof, mul_valid;
  logic [15:0] a_i, a_q, b_i, b_q, c_i, c_q, d_i, d_q;
  logic [19:0] mi1_i, mi1_q, mi2_i, mi2_q, mi3_i, mi3_q;
  logic ready, mul_en, ov, err;
  logic [17:0] md1_i, md1_q, md2_i, md2_q, md3_i, md3_q;
  logic [15:0] fi;
  logic [19:0] y0_i, y0_q, y1_i, y1_q, y2_i, y2_q, y3_i, y3_q;
  logic inv_ready, inv_mul_en, inv_ov, inv_err;
  logic [17:0] inv_d1_i, inv_d1_q, inv_d2_i, inv_d2_q, inv_d3_i, inv_d3_q;
  logic [15:0] inv_fi;
  logic [19:0] inv_y0_i, inv_y0_q, inv_y1_i, inv_y1_q, inv_y2_i, inv_y2_q, inv_y3_i, inv_y3_q;

  int errors = 0, checks = 0, cyc = 0, mk = 0, mul_allow = -1, nvalid = 0;
  bit ov_pend = 0, use_tbl = 0;
  exp_t tbl_exp;
  exp_t exp_iss[$];
  exp_t exp_out[$];
  mul_t mq[$];
  vec_t tv[13];

  fft_r4_bfly_issue dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready), .i_sof(sof),
    .i_a_i(a_i), .i_a_q(a_q), .i_b_i(b_i), .i_b_q(b_q),
    .i_c_i(c_i), .i_c_q(c_q), .i_d_i(d_i), .i_d_q(d_q),
    .o_mul_en(mul_en),
    .o_mul_data1_i(md1_i), .o_mul_data1_q(md1_q), .o_mul_data2_i(md2_i),
    .o_mul_data2_q(md2_q), .o_mul_data3_i(md3_i), .o_mul_data3_q(md3_q),
    .o_mul_fi_deg(fi), .i_mul_valid(mul_valid),
    .i_mul_data1_i(mi1_i), .i_mul_data1_q(mi1_q), .i_mul_data2_i(mi2_i),
    .i_mul_data2_q(mi2_q), .i_mul_data3_i(mi3_i), .i_mul_data3_q(mi3_q),
    .o_valid(ov), .o_y0_i(y0_i), .o_y0_q(y0_q), .o_y1_i(y1_i), .o_y1_q(y1_q),
    .o_y2_i(y2_i), .o_y2_q(y2_q), .o_y3_i(y3_i), .o_y3_q(y3_q), .o_err(err));

  fft_r4_bfly_issue #(.TYPE("invers")) dut_inv (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(inv_ready), .i_sof(sof),
    .i_a_i(a_i), .i_a_q(a_q), .i_b_i(b_i), .i_b_q(b_q),
    .i_c_i(c_i), .i_c_q(c_q), .i_d_i(d_i), .i_d_q(d_q),
    .o_mul_en(inv_mul_en),
    .o_mul_data1_i(inv_d1_i), .o_mul_data1_q(inv_d1_q), .o_mul_data2_i(inv_d2_i),
    .o_mul_data2_q(inv_d2_q), .o_mul_data3_i(inv_d3_i), .o_mul_data3_q(inv_d3_q),
    .o_mul_fi_deg(inv_fi), .i_mul_valid(1'b0),
    .i_mul_data1_i(20'd0), .i_mul_data1_q(20'd0), .i_mul_data2_i(20'd0),
    .i_mul_data2_q(20'd0), .i_mul_data3_i(20'd0), .i_mul_data3_q(20'd0),
    .o_valid(inv_ov), .o_y0_i(inv_y0_i), .o_y0_q(inv_y0_q), .o_y1_i(inv_y1_i),
    .o_y1_q(inv_y1_q), .o_y2_i(inv_y2_i), .o_y2_q(inv_y2_q), .o_y3_i(inv_y3_i),
    .o_y3_q(inv_y3_q), .o_err(inv_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Four-point DFT written directly from its definition (forward transform)
  function automatic exp_t ref_bfly(int ai, int aq, int bi, int bq, int ci, int cq, int di, int dq, int k);
    exp_t e;
    e.k   = k;
    e.y0i = ai + bi + ci + di;          e.y0q = aq + bq + cq + dq;
    e.y2i = ai - bi + ci - di;          e.y2q = aq - bq + cq - dq;
    e.y1i = (ai - ci) + (bq - dq);      e.y1q = (aq - cq) - (bi - di);
    e.y3i = (ai - ci) - (bq - dq);      e.y3q = (aq - cq) + (bi - di);
    return e;
  endfunction

  function automatic vec_t mkv(bit rst, bit s, int ai, int aq, int bi, int bq, int ci, int cq,
                               int di, int dq, int k, int y0i, int y0q, int y1i, int y1q,
                               int y2i, int y2q, int y3i, int y3q);
    vec_t v;
    v.rst = rst; v.sof = s;
    v.ai = ai; v.aq = aq; v.bi = bi; v.bq = bq; v.ci = ci; v.cq = cq; v.di = di; v.dq = dq;
    v.e.k = k; v.e.y0i = y0i; v.e.y0q = y0q; v.e.y1i = y1i; v.e.y1q = y1q;
    v.e.y2i = y2i; v.e.y2q = y2q; v.e.y3i = y3i; v.e.y3q = y3q;
    return v;
  endfunction

  function automatic logic [15:0] pick();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return 16'h8000;
    else if (r == 1) return 16'h7fff;
    else return 16'($urandom());
  endfunction

  task automatic rand_inputs(input bit s);
    valid = 1'b1; sof = s;
    a_i = pick(); a_q = pick(); b_i = pick(); b_q = pick();
    c_i = pick(); c_q = pick(); d_i = pick(); d_q = pick();
  endtask

  // One clock: score acceptance, observe outputs, run the multiplier model
  task automatic step(output bit acc);
    exp_t e;
    mul_t m;
    int use_k;
    acc = valid && ready;
    if (acc) begin
      use_k = sof ? 0 : mk;
      mk = (use_k + 1) % (NFFT / 4);
      if (use_tbl) e = tbl_exp;
      else e = ref_bfly($signed(a_i), $signed(a_q), $signed(b_i), $signed(b_q),
                        $signed(c_i), $signed(c_q), $signed(d_i), $signed(d_q), use_k);
      exp_iss.push_back(e);
      exp_out.push_back(e);
    end
    @(posedge clk); #1; cyc++;
    chk("mul_en", mul_en, acc);
    if (mul_en) begin
      chk("issue_expected", exp_iss.size() > 0, 1);
      if (exp_iss.size() > 0) begin
        e = exp_iss.pop_front();
        chk("fi_deg", fi, e.k);
        chk("d1_i", $signed(md1_i), e.y1i); chk("d1_q", $signed(md1_q), e.y1q);
        chk("d2_i", $signed(md2_i), e.y2i); chk("d2_q", $signed(md2_q), e.y2q);
        chk("d3_i", $signed(md3_i), e.y3i); chk("d3_q", $signed(md3_q), e.y3q);
      end
      m.due = cyc + LAT;
      m.d1i = {{2{md1_i[17]}}, md1_i}; m.d1q = {{2{md1_q[17]}}, md1_q};
      m.d2i = {{2{md2_i[17]}}, md2_i}; m.d2q = {{2{md2_q[17]}}, md2_q};
      m.d3i = {{2{md3_i[17]}}, md3_i}; m.d3q = {{2{md3_q[17]}}, md3_q};
      mq.push_back(m);
    end
    chk("o_valid", ov, ov_pend);
    if (ov) begin
      nvalid++;
      chk("out_expected", exp_out.size() > 0, 1);
      if (exp_out.size() > 0) begin
        e = exp_out.pop_front();
        chk("y0_i", $signed(y0_i), e.y0i); chk("y0_q", $signed(y0_q), e.y0q);
        chk("y1_i", $signed(y1_i), e.y1i); chk("y1_q", $signed(y1_q), e.y1q);
        chk("y2_i", $signed(y2_i), e.y2i); chk("y2_q", $signed(y2_q), e.y2q);
        chk("y3_i", $signed(y3_i), e.y3i); chk("y3_q", $signed(y3_q), e.y3q);
      end
    end
    chk("o_err", err, 0);
    ov_pend = 1'b0;
    mul_valid = 1'b0;
    if (mul_allow != 0 && mq.size() > 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      mi1_i = m.d1i; mi1_q = m.d1q; mi2_i = m.d2i; mi2_q = m.d2q; mi3_i = m.d3i; mi3_q = m.d3q;
      mul_valid = 1'b1;
      ov_pend = 1'b1;
      if (mul_allow > 0) mul_allow--;
    end
  endtask

  task automatic drain();
    bit a;
    int g;
    valid = 1'b0; g = 0;
    while (exp_out.size() > 0 && g < 100) begin
      step(a);
      g++;
    end
    chk("drain_left", exp_out.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b0; sof = 1'b0; mul_valid = 1'b0;
    {a_i, a_q, b_i, b_q, c_i, c_q, d_i, d_q} = '0;
    {mi1_i, mi1_q, mi2_i, mi2_q, mi3_i, mi3_q} = '0;
    exp_iss.delete(); exp_out.delete(); mq.delete();
    ov_pend = 1'b0; mk = 0;
    #1;
    chk("rst_outputs_zero", |{mul_en, ov, err, md1_i, md1_q, md2_i, md2_q, md3_i, md3_q, fi,
                              y0_i, y0_q, y1_i, y1_q, y2_i, y2_q, y3_i, y3_q,
                              inv_mul_en, inv_ov, inv_err, inv_d1_i, inv_d1_q, inv_d2_i,
                              inv_d2_q, inv_d3_i, inv_d3_q, inv_fi, inv_y0_i, inv_y0_q,
                              inv_y1_i, inv_y1_q, inv_y2_i, inv_y2_q, inv_y3_i, inv_y3_q}, 0);
    chk("rst_ready", ready & inv_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int kx[12] = '{0, 1, 2, 3, 0, 1, 0, 1, 0, 1, 2, 3};
    bit sx[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    bit a;
    int sent, g, nacc;
    rst_n = 1'b1; valid = 1'b0; sof = 1'b0; mul_valid = 1'b0;
    #2;

    tv[0] = mkv(1, 1, 100, 0, 0, 50, 20, 0, 0, -10, 0, 120, 40, 140, 0, 120, -40, 20, 0);
    for (int i = 0; i < 12; i++)
      tv[i+1] = mkv(i == 6, sx[i], 0, 0, 0, 0, 0, 0, 0, 0, kx[i], 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed table: butterfly vector and twiddle-counter sequences
    mul_allow = -1;
    for (int r = 0; r < 13; r++) begin
      if (tv[r].rst) begin
        if (r > 0) drain();
        do_reset();
      end
      valid = 1'b1; sof = tv[r].sof;
      a_i = 16'(tv[r].ai); a_q = 16'(tv[r].aq); b_i = 16'(tv[r].bi); b_q = 16'(tv[r].bq);
      c_i = 16'(tv[r].ci); c_q = 16'(tv[r].cq); d_i = 16'(tv[r].di); d_q = 16'(tv[r].dq);
      tbl_exp = tv[r].e; use_tbl = 1'b1;
      step(a);
      chk("tbl_accept", a, 1);
      if (r == 0) begin
        chk("inv_d1_i", $signed(inv_d1_i), 20);  chk("inv_d1_q", $signed(inv_d1_q), 0);
        chk("inv_d3_i", $signed(inv_d3_i), 140); chk("inv_d3_q", $signed(inv_d3_q), 0);
        chk("inv_d2_q", $signed(inv_d2_q), -40);
      end
    end
    use_tbl = 1'b0;
    drain();

    // Alignment: 20 random groups with random gaps
    do_reset();
    mul_allow = -1; nvalid = 0; sent = 0; g = 0;
    while (sent < 20 && g < 400) begin
      if ($urandom_range(0, 3) == 0) valid = 1'b0;
      else rand_inputs(sent == 0 || $urandom_range(0, 7) == 0);
      step(a);
      if (a) sent++;
      g++;
    end
    chk("align_sent", sent, 20);
    drain();
    chk("align_count", nvalid, 20);

    // Backpressure: multiplier withholds results
    do_reset();
    mul_allow = 0; nvalid = 0; nacc = 0;
    for (int i = 0; i < 12; i++) begin
      rand_inputs(i == 0);
      step(a);
      if (a) nacc++;
    end
    chk("bp_accepts", nacc, 8);
    chk("bp_ready_low", ready, 0);
    valid = 1'b0; mul_allow = 1;
    step(a);
    chk("bp_ready_still_low", ready, 0);
    step(a);
    chk("bp_ready_back", ready, 1);
    mul_allow = -1;
    drain();
    chk("bp_no_loss", nvalid, 8);

    // Mid-burst reset, then a late strobe must flag underflow
    for (int i = 0; i < 4; i++) begin
      rand_inputs(i == 0);
      step(a);
    end
    do_reset();
    mul_valid = 1'b1;
    @(posedge clk); #1;
    mul_valid = 1'b0;
    chk("uf_err_set", err, 1);
    chk("uf_no_valid", ov, 0);
    @(posedge clk); #1;
    chk("uf_err_sticky", err, 1);
    chk("uf_no_valid2", ov, 0);
    chk("uf_ready", ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
